// File: rtl/shift_sequencer_8bit_if.sv
// rtl/shift_sequencer_8bit_if.sv - request/result bundle between a controller and the shift sequencer
interface shift_sequencer_8bit_if #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
);
  logic             start;
  logic [WIDTH-1:0] x;
  logic [AMT_W-1:0] amt;
  logic [1:0]       op;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] f;
  logic             cout;

  modport master (
    output start, x, amt, op,
    input  busy, done, f, cout
  );

  modport slave (
    input  start, x, amt, op,
    output busy, done, f, cout
  );
endinterface

// File: rtl/shift_sequencer_8bit.sv
// rtl/shift_sequencer_8bit.sv - multi-bit shift run as one single-bit step per clock
module shift_sequencer_8bit #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input logic                 clk,
  input logic                 rst,
  shift_sequencer_8bit_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } state_t;

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] r_q, r_n;
  logic [WIDTH-1:0] f_q, f_n;
  logic [AMT_W-1:0] count_q, count_n;
  logic [1:0]       op_q, op_n;
  logic             carry_q, carry_n;
  logic             cout_q, cout_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      f_q     <= '0;
      count_q <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      r_q     <= r_n;
      f_q     <= f_n;
      count_q <= count_n;
      op_q    <= op_n;
      carry_q <= carry_n;
      cout_q  <= cout_n;
    end
  end

  always_comb begin
    state_n = S_IDLE;
    r_n     = r_q;
    f_n     = f_q;
    count_n = count_q;
    op_n    = op_q;
    carry_n = carry_q;
    cout_n  = cout_q;
    case (state_q)
      // DONE accepts a new request exactly like IDLE so operations can run back to back
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          r_n     = bus.x;
          count_n = bus.amt;
          op_n    = bus.op;
          carry_n = 1'b0;
          state_n = S_SHIFT;
        end
      end
      S_SHIFT: begin
        state_n = S_SHIFT;
        if (count_q != '0) begin
          count_n = count_q - AMT_W'(1);
          case (op_q)
            OP_SRL: begin
              r_n     = {1'b0, r_q[WIDTH-1:1]};
              carry_n = r_q[0];
            end
            OP_SLL: begin
              r_n     = {r_q[WIDTH-2:0], 1'b0};
              carry_n = r_q[WIDTH-1];
            end
            OP_SRA: begin
              r_n     = {r_q[WIDTH-1], r_q[WIDTH-1:1]};
              carry_n = r_q[0];
            end
            default: begin
              r_n     = {r_q[0], r_q[WIDTH-1:1]};
              carry_n = r_q[0];
            end
          endcase
        end else begin
          f_n     = r_q;
          cout_n  = carry_q;
          state_n = S_DONE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.busy = (state_q == S_SHIFT);
  assign bus.done = (state_q == S_DONE);
  assign bus.f    = f_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_shift_sequencer_8bit.sv
// tb/tb_shift_sequencer_8bit.sv - randomized self-checking bench for shift_sequencer_8bit
module tb_shift_sequencer_8bit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  logic [7:0] prev_f = 8'h00;
  logic       prev_c = 1'b0;

  shift_sequencer_8bit_if bus ();

  shift_sequencer_8bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Whole-operation reference: shift by n at once, carry is the last bit to leave
  function automatic logic [8:0] model(input logic [7:0] xv, input int n, input logic [1:0] o);
    int         v;
    int         s;
    logic [7:0] res;
    logic       c;
    v = int'(xv);
    s = xv[7] ? (v - 256) : v;
    c = 1'b0;
    case (o)
      2'd0: res = 8'(v >> n);
      2'd1: res = 8'(v << n);
      2'd2: res = 8'(s >>> n);
      default: res = 8'((v >> n) | (v << (8 - n)));
    endcase
    if (n != 0) c = (o == 2'd1) ? xv[8 - n] : xv[n - 1];
    return {c, res};
  endfunction

  // Issues a request (accepted from IDLE or DONE) and returns sitting in the DONE cycle
  task automatic run_op(input logic [7:0] xv, input int n, input logic [1:0] o, input bit noise);
    logic [8:0] exp;
    exp = model(xv, n, o);
    bus.start = 1'b1;
    bus.x     = xv;
    bus.amt   = 3'(n);
    bus.op    = o;
    tick();
    for (int i = 0; i <= n; i++) begin
      bus.start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      bus.x     = noise ? 8'hFF : 8'($urandom);
      bus.amt   = 3'($urandom);
      bus.op    = 2'($urandom);
      check("busy_in_shift", bus.busy, 1'b1);
      check("no_done_in_shift", bus.done, 1'b0);
      check("f_hold_in_shift", bus.f, prev_f);
      check("cout_hold_in_shift", bus.cout, prev_c);
      tick();
    end
    bus.start = 1'b0;
    check("done_pulse", bus.done, 1'b1);
    check("busy_clear_at_done", bus.busy, 1'b0);
    check("f_result", bus.f, exp[7:0]);
    check("cout_result", bus.cout, exp[8]);
    prev_f = exp[7:0];
    prev_c = exp[8];
  endtask

  initial begin
    bus.start = 1'b0;
    bus.x     = 8'h00;
    bus.amt   = 3'd0;
    bus.op    = 2'd0;
    rst       = 1'b1;
    repeat (2) tick();
    check("reset_busy", bus.busy, 1'b0);
    check("reset_done", bus.done, 1'b0);
    check("reset_f", bus.f, 8'h00);
    check("reset_cout", bus.cout, 1'b0);
    rst = 1'b0;
    tick();

    run_op(8'hFD, 1, 2'd0, 1'b0);
    check("plan1_f", bus.f, 8'h7E);
    check("plan1_cout", bus.cout, 1'b1);
    tick();
    check("done_one_cycle", bus.done, 1'b0);

    run_op(8'h8E, 3, 2'd2, 1'b0);
    check("plan2_f", bus.f, 8'hF1);
    check("plan2_cout", bus.cout, 1'b1);
    tick();

    run_op(8'hCD, 4, 2'd1, 1'b1);
    check("plan3_f", bus.f, 8'hD0);
    check("plan3_cout", bus.cout, 1'b0);
    tick();

    run_op(8'h8F, 7, 2'd3, 1'b0);
    check("plan4_f", bus.f, 8'h1F);
    check("plan4_cout", bus.cout, 1'b0);
    run_op(8'hA5, 0, 2'd0, 1'b0);
    check("plan4_b2b_f", bus.f, 8'hA5);
    check("plan4_b2b_cout", bus.cout, 1'b0);
    tick();
    check("idle_f_hold", bus.f, 8'hA5);

    bus.start = 1'b1;
    bus.x     = 8'h8F;
    bus.amt   = 3'd5;
    bus.op    = 2'd0;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    check("plan5_busy_before_rst", bus.busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("plan5_busy", bus.busy, 1'b0);
    check("plan5_done", bus.done, 1'b0);
    check("plan5_f", bus.f, 8'h00);
    check("plan5_cout", bus.cout, 1'b0);
    prev_f = 8'h00;
    prev_c = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_busy", bus.busy, 1'b0);
      check("idle_done", bus.done, 1'b0);
      check("idle_f", bus.f, 8'h00);
    end

    for (int t = 0; t < 40; t++) begin
      run_op(8'($urandom), int'($urandom_range(0, 7)), 2'($urandom), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) begin
        tick();
        check("rand_idle_done", bus.done, 1'b0);
        check("rand_idle_f", bus.f, prev_f);
        check("rand_idle_cout", bus.cout, prev_c);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
